// File: rtl/cva6_tlb_seq_ctrl.sv
// Sequencing controller for the CVA6 TLB: serialises SFENCE flushes and PTW
// refills onto the TLB ports and owns victim selection (tree PLRU, invalid first).
module cva6_tlb_seq_ctrl #(
  parameter int TLB_ENTRIES = 4,
  parameter int ASID_WIDTH  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_req_i,
  input  logic [ASID_WIDTH-1:0]   flush_asid_i,
  input  logic [31:0]             flush_vaddr_i,
  output logic                    flush_ack_o,
  input  logic                    upd_req_i,
  input  logic [61:0]             upd_data_i,
  output logic                    upd_ack_o,
  input  logic                    lu_hit_i,
  input  logic [TLB_ENTRIES-1:0]  lu_hit_idx_i,
  output logic                    tlb_flush_o,
  output logic [ASID_WIDTH-1:0]   tlb_asid_o,
  output logic [31:0]             tlb_vaddr_o,
  output logic [62:0]             tlb_update_o,
  output logic [TLB_ENTRIES-1:0]  replace_en_o,
  output logic                    busy_o
);

  localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam logic [TLB_ENTRIES-1:0] ENTRY0 = {{(TLB_ENTRIES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, UPDATE} state_t;

  state_t                 state_q;
  logic [TLB_ENTRIES-1:0] valid_q;
  logic [TLB_ENTRIES-2:0] plru_q;
  logic                   last_flush_q;
  logic [IDX_W-1:0]       victim_q;

  logic                   hit_ok;
  logic [IDX_W-1:0]       hit_idx;
  logic [TLB_ENTRIES-2:0] plru_hit;
  logic                   have_invalid;
  logic [IDX_W-1:0]       invalid_idx;
  logic [IDX_W-1:0]       victim_idx;
  logic                   grant_flush;
  logic                   grant_upd;

  // Point every node on the path to idx away from it.
  function automatic logic [TLB_ENTRIES-2:0] plru_touch(input logic [TLB_ENTRIES-2:0] tree,
                                                        input logic [IDX_W-1:0] idx);
    logic [TLB_ENTRIES-1:0] t;
    int node;
    t = {1'b0, tree};
    node = 0;
    for (int l = 0; l < IDX_W; l++) begin
      t[IDX_W'(node)] = ~idx[IDX_W-1-l];
      node = 2 * node + 1 + int'(idx[IDX_W-1-l]);
    end
    return t[TLB_ENTRIES-2:0];
  endfunction

  function automatic logic [IDX_W-1:0] plru_walk(input logic [TLB_ENTRIES-2:0] tree);
    logic [TLB_ENTRIES-1:0] t;
    logic [IDX_W-1:0] idx;
    logic b;
    int node;
    t = {1'b0, tree};
    idx = '0;
    node = 0;
    for (int l = 0; l < IDX_W; l++) begin
      b = t[IDX_W'(node)];
      idx[IDX_W-1-l] = b;
      node = 2 * node + 1 + int'(b);
    end
    return idx;
  endfunction

  always_comb begin
    hit_ok = lu_hit_i && (lu_hit_idx_i != '0) &&
             ((lu_hit_idx_i & (lu_hit_idx_i - ENTRY0)) == '0);
    hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (lu_hit_idx_i[i]) hit_idx = IDX_W'(i);
    end
    plru_hit = hit_ok ? plru_touch(plru_q, hit_idx) : plru_q;

    // Scan downwards so the lowest invalid index is the one that sticks.
    have_invalid = 1'b0;
    invalid_idx  = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        have_invalid = 1'b1;
        invalid_idx  = IDX_W'(i);
      end
    end
    victim_idx = have_invalid ? invalid_idx : plru_walk(plru_hit);

    grant_flush = flush_req_i && !(last_flush_q && upd_req_i);
    grant_upd   = upd_req_i && !grant_flush;
  end

  // Victim touch in UPDATE overrides any lookup-hit touch of the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      plru_q       <= '0;
      last_flush_q <= 1'b0;
      victim_q     <= '0;
      tlb_flush_o  <= 1'b0;
      flush_ack_o  <= 1'b0;
      upd_ack_o    <= 1'b0;
      tlb_update_o <= '0;
      replace_en_o <= '0;
      busy_o       <= 1'b0;
      tlb_asid_o   <= '0;
      tlb_vaddr_o  <= '0;
    end else begin
      plru_q <= plru_hit;
      case (state_q)
        IDLE: begin
          if (grant_flush) begin
            state_q     <= FLUSH;
            tlb_asid_o  <= flush_asid_i;
            tlb_vaddr_o <= flush_vaddr_i;
            tlb_flush_o <= 1'b1;
            busy_o      <= 1'b1;
          end else if (grant_upd) begin
            state_q      <= UPDATE;
            victim_q     <= victim_idx;
            tlb_update_o <= {1'b1, upd_data_i};
            replace_en_o <= ENTRY0 << victim_idx;
            upd_ack_o    <= 1'b1;
            busy_o       <= 1'b1;
          end
        end
        FLUSH: begin
          state_q     <= DRAIN;
          valid_q     <= '0;
          tlb_flush_o <= 1'b0;
          flush_ack_o <= 1'b1;
        end
        DRAIN: begin
          state_q      <= IDLE;
          flush_ack_o  <= 1'b0;
          last_flush_q <= 1'b1;
          busy_o       <= 1'b0;
        end
        UPDATE: begin
          state_q           <= IDLE;
          plru_q            <= plru_touch(plru_q, victim_q);
          valid_q[victim_q] <= 1'b1;
          tlb_update_o      <= '0;
          replace_en_o      <= '0;
          upd_ack_o         <= 1'b0;
          last_flush_q      <= 1'b0;
          busy_o            <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cva6_tlb_seq_ctrl.md
# cva6_tlb_seq_ctrl

Sequencing controller for the CVA6 fully-associative TLB. It arbitrates between SFENCE.VMA flush requests and PTW refill requests, and drives the TLB's flush and update ports one operation at a time. It also owns replacement: it chooses the victim entry and drives the one-hot replace enable, using tree pseudo-LRU with invalid-entry preference. It sits between the PTW/CSR-fence logic and `cva6_tlb_model`.

## Interface
- TLB_ENTRIES, 4, number of TLB entries; power of two, ≥ 2.
- ASID_WIDTH, 1, ASID width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous and active-low.
- flush_req_i  in  1  flush request; held high until flush_ack_o.
- flush_asid_i  in  ASID_WIDTH  ASID to flush; sampled at accept.
- flush_vaddr_i  in  32  vaddr to flush; sampled at accept.
- flush_ack_o  out  1  one-cycle pulse when the flush is complete.
- upd_req_i  in  1  refill request; held high until upd_ack_o.
- upd_data_i  in  62  refill payload; sampled at accept.
- upd_ack_o  out  1  one-cycle pulse when the refill is written.
- lu_hit_i  in  1  TLB lookup hit this cycle.
- lu_hit_idx_i  in  TLB_ENTRIES  one-hot index of the hit entry.
- tlb_flush_o  out  1  to TLB flush_i.
- tlb_asid_o  out  ASID_WIDTH  to TLB asid_to_be_flushed_i.
- tlb_vaddr_o  out  32  to TLB vaddr_to_be_flushed_i.
- tlb_update_o  out  63  to TLB update_i; bit 62 is valid, bits 61:0 are the payload.
- replace_en_o  out  TLB_ENTRIES  one-hot victim select, to TLB replace_en.
- busy_o  out  1  FSM is not in IDLE.

## Operation
- States: IDLE, FLUSH, DRAIN, UPDATE.
- IDLE → FLUSH when flush_req_i is high and flush wins arbitration; latch asid and vaddr.
- IDLE → UPDATE when upd_req_i is high and update wins arbitration; latch upd_data_i.
- FLUSH → DRAIN unconditionally.
- DRAIN → IDLE unconditionally.
- UPDATE → IDLE unconditionally.
- Arbitration in IDLE: flush has priority, except when the previous completed operation was a flush and upd_req_i is high. In that case the update wins, so updates cannot be starved by back-to-back flushes. The last-grant flag resets to "update".
- FLUSH: tlb_flush_o=1 and tlb_asid_o/tlb_vaddr_o carry the latched values. valid_q is cleared to all-zero. Every flush clears it, even a partial ASID/vaddr flush; this is conservative and affects replacement only.
- DRAIN: flush_ack_o=1.
- UPDATE:
  - tlb_update_o = {1'b1, latched data}.
  - replace_en_o = victim.
  - upd_ack_o=1.
  - valid_q[victim] is set and the PLRU is touched with the victim.
- Victim selection: the lowest-index entry with valid_q=0 if one exists, otherwise the PLRU victim.
- PLRU tree:
  - TLB_ENTRIES-1 bits; node 0 is the root, node i has children 2i+1 and 2i+2.
  - Bit 0 directs the walk to the lower-index half, bit 1 to the upper half.
  - Touching entry e sets every node on its path to point away from e.
- Touch sources: the UPDATE victim, and lu_hit_idx_i when lu_hit_i=1.
  - If both occur in the same cycle, the victim touch wins and the hit touch is dropped.
  - lu_hit_i with a non-one-hot index is ignored.
- Outputs outside their active state:
  - tlb_flush_o, flush_ack_o, upd_ack_o, tlb_update_o and replace_en_o are 0.
  - tlb_asid_o and tlb_vaddr_o hold their last latched values.
- No combinational path from any input to any output. Outputs are decoded from registered state and registered data only.

## Timing
- Reset (rst_ni=0 at an edge):
  - state=IDLE, valid_q=0, PLRU=0, last-grant=update, latches=0.
  - All outputs are 0 from the following cycle.
- A reset asserted mid-operation aborts the operation with no ack.
- Flush: request accepted at edge N; tlb_flush_o high in cycle N+1; flush_ack_o high in N+2; IDLE in N+3.
- Update: accepted at edge N; tlb_update_o[62], replace_en_o and upd_ack_o high in cycle N+1; IDLE in N+2.
- Requesters drop their request on the edge where ack is sampled. A request still high in the first cycle back in IDLE is treated as a new request.
- Requests are ignored while busy_o=1; they stay pending and no state is lost.

## Test plan
- Reset, then 4 updates with no hits → replace_en_o = 0001, 0010, 0100, 1000 in order; each upd_ack_o fires exactly 1 cycle after accept.
- Continue: a 5th update → 0001. Instead, a lu_hit on entry 0 before the 5th update → 5th replace_en_o = 0100.
- flush_req_i and upd_req_i raised together in IDLE at edge N:
  - tlb_flush_o in N+1, flush_ack_o in N+2.
  - UPDATE in N+4 even with flush_req_i held high.
  - That update uses replace_en_o=0001, because valid_q was cleared.
- lu_hit_i on entry 3 in the same cycle as an UPDATE with victim 0 → PLRU reflects only the touch of 0; the next victim after all entries are valid is 2.
- rst_ni pulled low during FLUSH → no flush_ack_o, all outputs 0, and the next update selects entry 0.
- Random update/flush streams with hits → replace_en_o is always one-hot in UPDATE and zero elsewhere, and busy_o matches state != IDLE.
